instruction_memory_param: RTL

Parametrised, writable instruction memory for the pipelined MIPS-style CPU, sitting between the PC/fetch stage and the decode stage. After reset it clears itself to NOP, and it accepts a program over a word-wise load port instead of relying on a hard-coded initial block. It returns one registered instruction per enabled fetch. An optional hazard interlock stalls the PC and issues NOP bubbles automatically, so programs no longer need hand-padded NOP gaps.

---
 rtl/instruction_memory_param.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_memory_param.sv
// instruction_memory_param
// Writable instruction memory between the fetch and decode stages.
//
// Modes (exposed on state_dbg):
//   CLEAR - sweeps every word to 0 (NOP) after reset, one word per cycle.
//   RUN   - serves one registered fetch per enabled cycle.
//   LOAD  - accepts program words over the load port.
//
// Optional feature macro: HAZARD_BUBBLE_EN
//   When defined, a load-use / RAW interlock compares the sources of the
//   word at Adress against the destinations of the last HAZARD_DEPTH
//   issued words, raises stall and issues NOP bubbles until the hazard
//   drains. When undefined, stall is tied low and no history exists.
//
// Load handshake: a program word is transferred on every rising clock edge
// where load_valid and load_ready are both high. load_ready is high for the
// whole time the block is in LOAD; load_valid may be driven freely, and a
// word presented while load_ready is low is simply not taken.

module instruction_memory_param #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 2**ADDR_WIDTH,
  parameter int HAZARD_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Adress,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  instr_valid,
  output logic                  stall,
  output logic                  busy,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_end,
  output logic                  load_ready,
  output logic [1:0]            state_dbg
);

  // Index width of the storage array; address bits above it only matter
  // for the out-of-range check.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   ptr_nxt;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic [DATA_WIDTH-1:0]   rom [DEPTH];
  logic                    addr_ok;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Pointer increment with wrap from the last word back to 0.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  // State and pointer register; reset restarts the clear sweep from 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state, pointer and write-port control.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_en     = 1'b0;
    wr_addr   = ptr;
    wr_data   = '0;
    case (state)
      ST_CLEAR: begin
        // load_start is deliberately ignored while clearing.
        wr_en   = 1'b1;
        ptr_nxt = ptr_inc(ptr);
        if (ptr == LAST_ADDR) begin
          state_nxt = ST_RUN;
          ptr_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_nxt = ST_LOAD;
          ptr_nxt   = load_addr;
        end
      end
      ST_LOAD: begin
        // A word accepted in the same cycle as a re-base goes to the old
        // pointer; the re-base then overrides the increment.
        if (load_valid) begin
          wr_en   = 1'b1;
          wr_data = load_data;
          ptr_nxt = ptr_inc(ptr);
        end
        if (load_start) begin
          ptr_nxt = load_addr;
        end
        if (load_end) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Single write port shared by the clear sweep and the loader.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      rom[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Asynchronous array read; addresses beyond DEPTH read as NOP.
  always_comb begin
    addr_ok = ({1'b0, Adress} < DEPTH_EXT);
    rd_word = addr_ok ? rom[Adress[IDX_W-1:0]] : '0;
  end

  assign busy       = (state == ST_CLEAR);
  assign load_ready = (state == ST_LOAD);
  assign state_dbg  = state;

`ifdef HAZARD_BUBBLE_EN
  logic [4:0] hist [HAZARD_DEPTH];
  logic [4:0] dec_dest;
  logic [4:0] dec_src_a;
  logic [4:0] dec_src_b;
  logic       hazard;
  logic       hist_clr;

  // The history restarts empty whenever RUN is entered from another mode.
  assign hist_clr = (state != ST_RUN) && (state_nxt == ST_RUN);

  // Decode the candidate word and compare its sources with the history.
  // Register 0 is never a source, so zero entries can never match.
  always_comb begin
    dec_dest  = '0;
    dec_src_a = '0;
    dec_src_b = '0;
    case (rd_word[31:26])
      6'd6: begin
        dec_dest  = rd_word[25:21];
        dec_src_a = rd_word[20:16];
        dec_src_b = rd_word[15:11];
      end
      6'd7: begin
        dec_dest  = rd_word[25:21];
        dec_src_a = rd_word[20:16];
      end
      6'd8: begin
        dec_src_a = rd_word[25:21];
        dec_src_b = rd_word[20:16];
      end
      default: begin
      end
    endcase
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (((dec_src_a != 5'd0) && (dec_src_a == hist[i])) ||
          ((dec_src_b != 5'd0) && (dec_src_b == hist[i]))) begin
        hazard = 1'b1;
      end
    end
  end

  assign stall = (state == ST_RUN) && fetch_en && hazard;

  // Destination history: shifts once per enabled RUN fetch, a bubble
  // pushes 0 so the hazard drains after HAZARD_DEPTH cycles at most.
  always_ff @(posedge clock) begin
    if (reset || hist_clr) begin
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else if ((state == ST_RUN) && fetch_en) begin
      for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
        hist[i] <= hist[i-1];
      end
      hist[0] <= stall ? 5'd0 : dec_dest;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // Registered fetch output; bubbles are valid NOPs, idle cycles are not.
  always_ff @(posedge clock) begin
    if (reset) begin
      Instruction <= '0;
      instr_valid <= 1'b0;
    end else if ((state == ST_RUN) && fetch_en) begin
      Instruction <= stall ? '0 : rd_word;
      instr_valid <= 1'b1;
    end else begin
      Instruction <= '0;
      instr_valid <= 1'b0;
    end
  end

endmodule
